// File: rtl/counter_share_arb.sv
// Round-robin arbiter sharing one loadable down-counter among NREQ requesters.
// Define COUNTER_SHARE_ABORT_EN to let a requester abort its run by dropping req during COUNT.
//
// state   | meaning
// IDLE    | no run; arbitrate among pending requests
// LOAD    | winner granted; counter loads the winner's length
// COUNT   | counter decrements towards zero
// DONE    | one-cycle done pulse to the winner
module counter_share_arb #(
  parameter int NREQ = 4,
  parameter int W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] len_i,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [W-1:0]      cnt_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   win_q, win_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [W-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]   pick;
  logic            pick_vld;
  logic [PW-1:0]   win_nxt;
  logic [NREQ-1:0] win_oh;

  // Rotating search: first set request at or after ptr_q, wrapping modulo NREQ.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr_q) + i) % NREQ;
      if (!pick_vld && req[idx]) begin
        pick     = PW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  assign win_nxt = (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          win_d   = pick;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = len_i[int'(win_q)*W +: W];
        state_d = S_COUNT;
      end
      S_COUNT: begin
`ifdef COUNTER_SHARE_ABORT_EN
        if (!req[win_q]) begin
          state_d = S_IDLE;
          ptr_d   = win_nxt;
        end else if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - W'(1);
        end
`else
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - W'(1);
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
        ptr_d   = win_nxt;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode straight from registered state so reset clears them at once.
  always_comb begin
    win_oh        = '0;
    win_oh[win_q] = 1'b1;
  end

  assign gnt   = (state_q != S_IDLE) ? win_oh : '0;
  assign done  = (state_q == S_DONE) ? win_oh : '0;
  assign busy  = (state_q != S_IDLE);
  assign cnt_o = cnt_q;

endmodule

// File: tb/tb_counter_share_arb.sv
// Self-checking bench for counter_share_arb: directed scenarios plus random traffic
// compared every cycle against an elapsed-time reference model.
module tb_counter_share_arb;

  localparam int N = 4;
  localparam int W = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] len_i;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           busy;
  logic [W-1:0]   cnt_o;

  int checks = 0;
  int errors = 0;

  // Reference model: a run is described by the winner, its length and the
  // number of cycles elapsed since it was granted.
  bit m_busy;
  int m_win, m_t, m_len, m_ptr, m_cnt;

  counter_share_arb #(.NREQ(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .len_i (len_i),
    .gnt   (gnt),
    .done  (done),
    .busy  (busy),
    .cnt_o (cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_win  = 0;
    m_t    = 0;
    m_len  = 0;
    m_ptr  = 0;
    m_cnt  = 0;
  endtask

  task automatic model_step();
    bit found;
    bit aborted;
    if (!m_busy) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!found && req[(m_ptr + k) % N]) begin
          m_win = (m_ptr + k) % N;
          found = 1'b1;
        end
      end
      if (found) begin
        m_busy = 1'b1;
        m_t    = 1;
      end
    end else begin
      aborted = 1'b0;
`ifdef COUNTER_SHARE_ABORT_EN
      if (m_t >= 2 && m_t <= m_len + 2 && !req[m_win]) begin
        m_busy  = 1'b0;
        m_ptr   = (m_win + 1) % N;
        aborted = 1'b1;
      end
`endif
      if (!aborted) begin
        if (m_t == 1) m_len = int'(len_i[m_win*W +: W]);
        m_t++;
        if (m_t == m_len + 4) begin
          m_busy = 1'b0;
          m_ptr  = (m_win + 1) % N;
        end else begin
          m_cnt = (m_t - 2 >= m_len) ? 0 : m_len - (m_t - 2);
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] e_gnt, e_done;
    e_gnt  = '0;
    e_done = '0;
    if (m_busy) begin
      e_gnt[m_win] = 1'b1;
      if (m_t == m_len + 3) e_done[m_win] = 1'b1;
    end
    chk("gnt",  gnt,   e_gnt);
    chk("done", done,  e_done);
    chk("busy", busy,  m_busy);
    chk("cnt",  cnt_o, m_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    int order[$];
    logic [N-1:0] prev_gnt, remask;
    bit seen;
    rst_n = 1'b0;
    req   = '0;
    len_i = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Single request, length 3.
    req   = 4'b0010;
    len_i = 16'h0030;
    tick();
    chk("single_gnt", gnt, 4'b0010);
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) chk("single_cnt_load", cnt_o, 3);
      if (k == 5) begin
        chk("single_done", done, 4'b0010);
        req = '0;
      end
      if (k == 6) chk("single_busy_low", busy, 0);
    end

    // Zero length.
    req   = 4'b0001;
    len_i = 16'h0030;
    tick();
    tick();
    chk("zero_cnt", cnt_o, 0);
    tick();
    chk("zero_done", done, 4'b0001);
    req = '0;
    tick();
    chk("zero_busy_low", busy, 0);

    // Asynchronous reset in the middle of COUNT.
    req   = 4'b0100;
    len_i = 16'h0900;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", cnt_o, 0);
    model_reset();
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin fairness with every requester pending.
    req      = 4'b1111;
    len_i    = 16'h1111;
    prev_gnt = '0;
    remask   = '0;
    for (int c = 0; c < 60 && order.size() < 5; c++) begin
      tick();
      if (gnt != 0 && prev_gnt == 0)
        for (int i = 0; i < N; i++) if (gnt[i]) order.push_back(i);
      prev_gnt = gnt;
      req      = req | remask;
      remask   = '0;
      if (done != 0) begin
        req    = req & ~done;
        remask = done;
      end
    end
    chk("rr_grants", order.size(), 5);
    for (int k = 0; k < order.size(); k++) chk("rr_order", order[k], k % N);
    req = 4'b0001;
    for (int c = 0; c < 20 && busy; c++) begin
      tick();
      if (done[0]) req = '0;
    end
    req = '0;
    tick();
    chk("rr_idle", busy, 0);

    // A request arriving mid-run waits for the current run to finish.
    req   = 4'b0001;
    len_i = 16'h0204;
    tick();
    tick();
    req  = 4'b0101;
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (!seen) chk("wait_no_gnt2", gnt[2], 0);
      if (done[0]) begin
        req[0] = 1'b0;
        seen   = 1'b1;
      end else if (seen && gnt != 0) begin
        chk("wait_next", gnt, 4'b0100);
        break;
      end
    end
    chk("wait_seen_done0", seen, 1);
    for (int c = 0; c < 20 && busy; c++) begin
      tick();
      if (done[2]) req = '0;
    end
    req = '0;
    tick();

    // Requester 3 drops its request while the counter shows 5.
    req   = 4'b1000;
    len_i = 16'h9000;
    seen  = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      tick();
      if (busy && cnt_o == 5) seen = 1'b1;
    end
    chk("abort_reach5", seen, 1);
    req = '0;
    tick();
`ifdef COUNTER_SHARE_ABORT_EN
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_cnt_hold", cnt_o, 5);
    req = 4'b1001;
    tick();
    chk("abort_ptr_wrap", gnt, 4'b0001);
    req = 4'b0001;
    for (int c = 0; c < 20 && busy; c++) begin
      tick();
      if (done[0]) req = '0;
    end
`else
    seen = 1'b0;
    for (int c = 0; c < 20 && busy; c++) begin
      if (done[3]) seen = 1'b1;
      tick();
    end
    chk("noabort_done3", seen, 1);
`endif
    req = '0;
    tick();
    chk("abort_idle", busy, 0);

    // Random traffic checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (done[i]) begin
            if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
          end else if ($urandom_range(0, 63) == 0) begin
            req[i] = 1'b0;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
        end
        len_i[i*W +: W] = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 5));
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
